// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It owns the PC and issues one read at a time to
//   instruction memory over a req/ack handshake. The fetched word is handed to
//   the controller/datapath together with its PC and PC+8 (the R15 read value).
//   When the consumed instruction redirects (PCSrc), the next fetch goes to
//   branch_target; otherwise it goes to PC+4. A memory that never acks, or a
//   misaligned redirect target, parks the unit in a sticky error state.
//
// Ports
//   clk, reset                clock (rising edge), async active-low reset
//   imem_req/imem_addr        read request and word-aligned address
//   imem_rdata/imem_ack       read data, valid in the ack cycle only
//   instr_valid/instr_ready   handshake toward the controller/datapath
//   PCSrc/branch_target       redirect, sampled when an instruction is consumed
//   Instr/pc/pc_plus8         fetched word, its address, address + 8
//   fetch_err                 sticky trap flag (timeout or misaligned target)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic [31:0] Instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Low bits forced to zero so the PC can never become misaligned.
    localparam logic [31:0] PC_RST   = {RESET_PC[31:2], 2'b00};
    // The request is held for exactly TIMEOUT cycles; the last one is still
    // allowed to carry the ack.
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;
    logic [7:0]  timer_q;

    logic [31:0] pc_d;
    logic        tgt_bad;

    // Next fetch address for the instruction being consumed (mod 2^32).
    assign pc_d    = PCSrc ? branch_target : pc_q + 32'd4;
    assign tgt_bad = PCSrc && (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= PC_RST;
            instr_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= 8'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Any ack seen here belongs to a request killed by reset.
                    state_q <= ISSUE;
                    req_q   <= 1'b1;
                    timer_q <= 8'h0;
                end
                ISSUE: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        timer_q <= 8'h0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end else if (timer_q == TMO_LAST) begin
                        timer_q <= 8'h0;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (tgt_bad) begin
                            // PC is left pointing at the offending instruction.
                            err_q   <= 1'b1;
                            state_q <= ERROR;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= ERROR;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + 32'd8;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Random memory latency / consumer backpressure / redirects against a simple
//   model: model_pc is the address the next fetched instruction must come
//   from; every ack pushes {model_pc, mem(model_pc)} into a queue, and a
//   separate monitor pops one entry per presented instruction and compares.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] Instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .branch_target(branch_target),
        .Instr(Instr), .pc(pc), .pc_plus8(pc_plus8), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // stimulus knobs / model state
    int          lat_max = 0, lat = 0, wait_cnt = 0;
    int          ready_pct = 100, pcsrc_pct = 0;
    bit          mute = 1'b0, force_br = 1'b0, log_en = 1'b0;
    logic [31:0] force_tgt = 32'h0;
    logic [31:0] model_pc = 32'h0;
    int          cyc = 0;
    bit          last_req;
    logic [31:0] last_addr;
    int          vld_cyc[$];
    logic [31:0] addr_log[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: sample at negedge, drive inputs for the next posedge.
    task automatic step();
        int r;
        @(negedge clk);
        cyc++;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (log_en && instr_valid) vld_cyc.push_back(cyc);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req && !mute) begin
            if (wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_f(imem_addr);
                exp_q.push_back('{a: model_pc, d: mem_f(model_pc)});
                if (log_en) addr_log.push_back(imem_addr);
                wait_cnt = 0;
                lat = $urandom_range(lat_max, 0);
            end else begin
                wait_cnt++;
            end
        end
        // redirect inputs are junk unless an instruction is consumed
        instr_ready   = 1'b0;
        PCSrc         = 1'($urandom);
        branch_target = $urandom;
        if (instr_valid && ($urandom_range(99, 0) < ready_pct)) begin
            instr_ready = 1'b1;
            if (force_br) begin
                PCSrc = 1'b1;
                branch_target = force_tgt;
                force_br = 1'b0;
            end else if ($urandom_range(99, 0) < pcsrc_pct) begin
                PCSrc = 1'b1;
                r = $urandom_range(3, 0);
                branch_target = (r == 0) ? 32'hFFFF_FFF8 :
                                (r == 1) ? 32'hFFFF_FFFC :
                                {$urandom_range(32'hFFFF, 0) * 32'd4};
            end else begin
                PCSrc = 1'b0;
            end
            model_pc = PCSrc ? branch_target : model_pc + 32'd4;
        end
    endtask

    task automatic wait_req(input string nm, input logic [31:0] exp_addr);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_req && n < 40);
        chk(nm, last_req ? last_addr : 32'hXXXX_XXXX, exp_addr);
    endtask

    task automatic consume_force(input logic [31:0] tgt);
        int n = 0;
        force_tgt = tgt;
        force_br  = 1'b1;
        while (force_br && n < 50) begin
            step();
            n++;
        end
        chk("force_consumed", {31'h0, force_br}, 32'h0);
        force_br = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
        wait_cnt = 0;
        lat = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: one expected entry per instruction presentation; the entry is
    // re-checked every cycle the instruction is held.
    initial begin
        exp_t cur;
        bit   have_cur = 1'b0;
        forever begin
            @(negedge clk);
            chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (reset && instr_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_instr: got pc %h with no fetch pending", pc);
                        cur = '{a: pc, d: Instr};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    have_cur = 1'b1;
                end
                chk("pc", pc, cur.a);
                chk("Instr", Instr, cur.d);
                chk("pc_plus8", pc_plus8, cur.a + 32'd8);
                chk("req_while_valid", {31'h0, imem_req}, 32'h0);
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] saved;

        // reset state
        #3;
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_err",   {31'h0, fetch_err},   32'h0);
        chk("rst_Instr", Instr, 32'h0);
        chk("rst_pc",    pc,    32'h0);
        chk("rst_pc8",   pc_plus8, 32'h8);

        // first fetch, zero-wait memory
        @(negedge clk);
        reset  = 1'b1;
        log_en = 1'b1;
        n = 0;
        do begin step(); n++; end while (!imem_ack && n < 10);
        chk("first_ack", {31'h0, imem_ack}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_Instr", Instr, 32'hE3A0_1005);
        chk("first_pc", pc, 32'h0);
        chk("first_pc8", pc_plus8, 32'h8);

        // sequential run at full rate
        n = 0;
        while (vld_cyc.size() < 4 && n < 40) begin step(); n++; end
        chk("seq_count", vld_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < vld_cyc.size(); i++)
            chk("seq_period", vld_cyc[i] - vld_cyc[i-1], 32'd2);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("seq_addr", addr_log[i], 32'(i * 4));
        log_en = 1'b0;

        // branch redirect
        consume_force(32'h40);
        wait_req("branch_addr", 32'h40);

        // backpressure: hold the instruction for 5 cycles
        ready_pct = 0;
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        repeat (5) step();
        chk("bp_valid", {31'h0, instr_valid}, 32'h1);
        chk("bp_req",   {31'h0, imem_req},    32'h0);
        ready_pct = 100;

        // wrap-around from the top of the address space
        consume_force(32'hFFFF_FFFC);
        wait_req("wrap_top", 32'hFFFF_FFFC);
        wait_req("wrap_zero", 32'h0);

        // randomized run
        lat_max = 4;
        ready_pct = 70;
        pcsrc_pct = 25;
        repeat (400) step();
        chk("rand_no_err", {31'h0, fetch_err}, 32'h0);

        // misaligned redirect target
        ready_pct = 100;
        pcsrc_pct = 0;
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        saved = model_pc;
        consume_force(32'h42);
        repeat (3) step();
        chk("mis_err",   {31'h0, fetch_err},   32'h1);
        chk("mis_req",   {31'h0, imem_req},    32'h0);
        chk("mis_valid", {31'h0, instr_valid}, 32'h0);
        chk("mis_pc",    pc, saved);

        // async reset in the middle of a request, then a late ack in IDLE
        lat_max = 0;
        do_reset();
        chk("rst2_err", {31'h0, fetch_err}, 32'h0);
        mute = 1'b1;
        n = 0;
        do begin step(); n++; end while (!imem_req && n < 10);
        #2;
        reset = 1'b0;
        #1;
        chk("async_req",   {31'h0, imem_req},    32'h0);
        chk("async_valid", {31'h0, instr_valid}, 32'h0);
        chk("async_err",   {31'h0, fetch_err},   32'h0);
        chk("async_pc",    pc, 32'h0);
        exp_q.delete();
        model_pc = 32'h0;
        wait_cnt = 0;
        lat = 0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("late_ack_req",   {31'h0, imem_req},    32'h1);
        chk("late_ack_addr",  imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        mute = 1'b0;
        n = 0;
        while (!instr_valid && n < 10) begin step(); n++; end
        chk("restart_Instr", Instr, 32'hE3A0_1005);
        repeat (6) step();

        // ack timeout
        do_reset();
        mute = 1'b1;
        n = 0;
        do begin step(); n++; end while (!imem_req && n < 10);
        n = 1;
        while (n < 40) begin
            step();
            if (!last_req) break;
            n++;
        end
        chk("tmo_req_cycles", n, 32'(TMO));
        repeat (5) step();
        chk("tmo_err",   {31'h0, fetch_err},   32'h1);
        chk("tmo_req",   {31'h0, imem_req},    32'h0);
        chk("tmo_valid", {31'h0, instr_valid}, 32'h0);
        chk("tmo_pending", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
